// File: rtl/mat_vec_mult.sv
// Signed matrix-vector multiplier y = A*x with serial A/x load, compute, and streamed y output.
// Optional accumulator saturation is enabled by defining MVM_SATURATE_EN (default: wrap-around).
module mat_vec_mult #(
  parameter int MAT_SCALE   = 20,
  parameter int PARALLEL    = 1,
  parameter int INPUT_WIDTH = 8,
  parameter int PIPELINE    = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                loadMatrix,
  input  logic                                loadVector,
  input  logic                                start,
  output logic                                done,
  input  logic signed [INPUT_WIDTH-1:0]       data_in,
  output logic signed [2*INPUT_WIDTH-1:0]     data_out
);

  localparam int N   = MAT_SCALE;
  localparam int P   = PARALLEL;
  localparam int W   = INPUT_WIDTH;
  localparam int OW  = 2 * INPUT_WIDTH;
  localparam int OW1 = OW + 1;
  localparam int G   = N / P;
  localparam int AW  = $clog2(N * N);
  localparam int CW  = $clog2(N);
  localparam int GW  = (G > 1) ? $clog2(G) : 1;

`ifdef MVM_SATURATE_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  localparam logic signed [OW-1:0] MAX_VAL = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] MIN_VAL = {1'b1, {(OW-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_M  = 3'd1,
    LOAD_V  = 3'd2,
    COMPUTE = 3'd3,
    DONE    = 3'd4,
    OUTPUT  = 3'd5
  } state_t;

  // Returns {overflow, sum}; overflow can only be flagged when saturation is enabled.
  function automatic logic [OW:0] acc_add(input logic signed [OW-1:0] a,
                                          input logic signed [OW-1:0] b);
    logic signed [OW:0] sum_v;
    logic               ovf_v;
    sum_v = OW1'(a) + OW1'(b);
    ovf_v = SAT_EN && (sum_v[OW] != sum_v[OW-1]);
    if (ovf_v) begin
      if (sum_v[OW]) return {1'b1, MIN_VAL};
      else           return {1'b1, MAX_VAL};
    end else begin
      return {1'b0, sum_v[OW-1:0]};
    end
  endfunction

  state_t                 state_r;
  logic [AW-1:0]          ld_cnt_r;
  logic [CW-1:0]          col_r;
  logic [GW-1:0]          grp_r;
  logic                   issue_done_r;
  logic [CW-1:0]          out_idx_r;

  logic signed [W-1:0]    a_mem_r [N*N];
  logic signed [W-1:0]    x_mem_r [N];
  logic signed [OW-1:0]   y_mem_r [N];

  logic                   s0_valid_s, s0_first_s, s0_last_s, s0_final_s;
  logic signed [OW-1:0]   s0_prod_s [P];
  logic                   d_valid_s, d_first_s, d_last_s, d_final_s;
  logic [GW-1:0]          d_grp_s;
  logic signed [OW-1:0]   d_prod_s [P];

  logic signed [OW-1:0]   acc_r [P];
  logic                   sticky_r [P];
  logic signed [OW-1:0]   acc_next_s [P];
  logic                   sticky_next_s [P];
  logic [OW:0]            add_s [P];

  // Issue stage: MAC p works on row grp*P+p, column col, one column per cycle.
  always_comb begin
    s0_valid_s = (state_r == COMPUTE) && !issue_done_r;
    s0_first_s = (col_r == CW'(0));
    s0_last_s  = (col_r == CW'(N-1));
    s0_final_s = s0_last_s && (grp_r == GW'(G-1));
    for (int p = 0; p < P; p++) begin
      s0_prod_s[p] = OW'(a_mem_r[AW'((int'(grp_r) * P + p) * N + int'(col_r))])
                   * OW'(x_mem_r[col_r]);
    end
  end

  generate
    if (PIPELINE > 0) begin : g_pipe
      logic                 p1_valid_r, p1_first_r, p1_last_r, p1_final_r;
      logic [GW-1:0]        p1_grp_r;
      logic signed [OW-1:0] p1_prod_r [P];

      // Register stage between the multipliers and the accumulators.
      always_ff @(posedge clk) begin
        if (reset) begin
          p1_valid_r <= 1'b0;
          p1_first_r <= 1'b0;
          p1_last_r  <= 1'b0;
          p1_final_r <= 1'b0;
          p1_grp_r   <= GW'(0);
          for (int p = 0; p < P; p++) p1_prod_r[p] <= OW'(0);
        end else begin
          p1_valid_r <= s0_valid_s;
          p1_first_r <= s0_first_s;
          p1_last_r  <= s0_last_s;
          p1_final_r <= s0_final_s;
          p1_grp_r   <= grp_r;
          for (int p = 0; p < P; p++) p1_prod_r[p] <= s0_prod_s[p];
        end
      end

      assign d_valid_s = p1_valid_r;
      assign d_first_s = p1_first_r;
      assign d_last_s  = p1_last_r;
      assign d_final_s = p1_final_r;
      assign d_grp_s   = p1_grp_r;
      assign d_prod_s  = p1_prod_r;
    end else begin : g_nopipe
      assign d_valid_s = s0_valid_s;
      assign d_first_s = s0_first_s;
      assign d_last_s  = s0_last_s;
      assign d_final_s = s0_final_s;
      assign d_grp_s   = grp_r;
      assign d_prod_s  = s0_prod_s;
    end
  endgenerate

  // Accumulator next value; once clamped, a row keeps its clamp until the next row starts.
  always_comb begin
    for (int p = 0; p < P; p++) begin
      add_s[p] = acc_add(acc_r[p], d_prod_s[p]);
      if (d_first_s) begin
        acc_next_s[p]    = d_prod_s[p];
        sticky_next_s[p] = 1'b0;
      end else if (sticky_r[p]) begin
        acc_next_s[p]    = acc_r[p];
        sticky_next_s[p] = 1'b1;
      end else begin
        acc_next_s[p]    = add_s[p][OW-1:0];
        sticky_next_s[p] = add_s[p][OW];
      end
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < P; p++) begin
        acc_r[p]    <= OW'(0);
        sticky_r[p] <= 1'b0;
      end
    end else if (d_valid_s) begin
      for (int p = 0; p < P; p++) begin
        acc_r[p]    <= acc_next_s[p];
        sticky_r[p] <= sticky_next_s[p];
      end
    end
  end

  // Storage for A, x and y; deliberately untouched by reset so contents survive it.
  always_ff @(posedge clk) begin
    if (!reset && state_r == LOAD_M) a_mem_r[ld_cnt_r] <= data_in;
    if (!reset && state_r == LOAD_V) x_mem_r[ld_cnt_r[CW-1:0]] <= data_in;
    if (!reset && d_valid_s && d_last_s) begin
      for (int p = 0; p < P; p++) y_mem_r[CW'(int'(d_grp_s) * P + p)] <= acc_next_s[p];
    end
  end

  // Control FSM with registered done/data_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      done         <= 1'b0;
      data_out     <= OW'(0);
      ld_cnt_r     <= AW'(0);
      col_r        <= CW'(0);
      grp_r        <= GW'(0);
      issue_done_r <= 1'b0;
      out_idx_r    <= CW'(0);
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          ld_cnt_r <= AW'(0);
          if (loadMatrix) begin
            state_r <= LOAD_M;
          end else if (loadVector) begin
            state_r <= LOAD_V;
          end else if (start) begin
            state_r      <= COMPUTE;
            col_r        <= CW'(0);
            grp_r        <= GW'(0);
            issue_done_r <= 1'b0;
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD_M: begin
          ld_cnt_r <= ld_cnt_r + AW'(1);
          if (ld_cnt_r == AW'(N*N-1)) state_r <= IDLE;
        end
        LOAD_V: begin
          ld_cnt_r <= ld_cnt_r + AW'(1);
          if (ld_cnt_r == AW'(N-1)) state_r <= IDLE;
        end
        COMPUTE: begin
          if (!issue_done_r) begin
            if (col_r == CW'(N-1)) begin
              col_r <= CW'(0);
              if (grp_r == GW'(G-1)) issue_done_r <= 1'b1;
              else                   grp_r <= grp_r + GW'(1);
            end else begin
              col_r <= col_r + CW'(1);
            end
          end
          // Final row write lands this edge, so y is complete during the DONE cycle.
          if (d_valid_s && d_final_s) begin
            state_r <= DONE;
            done    <= 1'b1;
          end
        end
        DONE: begin
          data_out  <= y_mem_r[0];
          out_idx_r <= CW'(1);
          state_r   <= OUTPUT;
        end
        OUTPUT: begin
          data_out  <= y_mem_r[out_idx_r];
          out_idx_r <= out_idx_r + CW'(1);
          if (out_idx_r == CW'(N-1)) state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_vec_mult.sv
// Directed table-driven bench for mat_vec_mult plus reset, back-to-back and random sequences.
module tb_mat_vec_mult;

  localparam int N = 20;

  logic               clk = 1'b0;
  logic               reset, loadMatrix, loadVector, start, done;
  logic signed [7:0]  data_in;
  logic signed [15:0] data_out;

  int n_cmp = 0;
  int n_err = 0;
  int a_tb[N*N];
  int x_tb[N];
  int exp_y[N];

  typedef struct {
    int    ident;
    int    a_val;
    int    x_base;
    int    x_step;
    int    e_base;
    int    e_step;
    string name;
  } vec_t;

  vec_t tbl[7];

`ifdef MVM_SATURATE_EN
  localparam int EXP_C127 = 32767;
  localparam int EXP_CMIN = 32767;
`else
  localparam int EXP_C127 = -5100;
  localparam int EXP_CMIN = 0;
`endif

  always #5 clk = ~clk;

  mat_vec_mult #(.MAT_SCALE(20), .PARALLEL(1), .INPUT_WIDTH(8), .PIPELINE(1)) dut (
    .clk(clk), .reset(reset), .loadMatrix(loadMatrix), .loadVector(loadVector),
    .start(start), .done(done), .data_in(data_in), .data_out(data_out)
  );

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic load_matrix();
    @(negedge clk); loadMatrix = 1'b1;
    for (int i = 0; i < N*N; i++) begin
      @(negedge clk); loadMatrix = 1'b0; data_in = 8'(a_tb[i]);
    end
  endtask

  task automatic load_vector();
    @(negedge clk); loadVector = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk); loadVector = 1'b0; data_in = 8'(x_tb[i]);
    end
  endtask

  // Reference: exact integer dot product, reduced modulo 2^16.
  task automatic model_y();
    logic signed [15:0] t;
    for (int j = 0; j < N; j++) begin
      int s = 0;
      for (int k = 0; k < N; k++) s += a_tb[j*N+k] * x_tb[k];
      t = 16'(s);
      exp_y[j] = int'(t);
    end
  endtask

  task automatic run_start(input string tag, input bit pulse_lm);
    bit seen = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, " done_after_start"}, int'(done), 0);
    for (int c = 0; c < 1000 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({tag, " done_seen"}, int'(seen), 1);
    if (!seen) return;
    for (int j = 0; j < N; j++) begin
      @(negedge clk);
      if (pulse_lm) loadMatrix = (j == 5);
      if (j == 0) check({tag, " done_width"}, int'(done), 0);
      check($sformatf("%s y[%0d]", tag, j), int'(data_out), exp_y[j]);
    end
    loadMatrix = 1'b0;
  endtask

  task automatic fill(input vec_t v);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        a_tb[r*N+c] = (v.ident != 0) ? ((r == c) ? v.a_val : 0) : v.a_val;
    for (int k = 0; k < N; k++) x_tb[k] = v.x_base + k * v.x_step;
    for (int j = 0; j < N; j++) exp_y[j] = v.e_base + j * v.e_step;
  endtask

  initial begin
    int rst_op;
    tbl[0] = '{1,    1,    1, 1,      1, 1, "ident"};
    tbl[1] = '{0,   40,  -40, 0, -32000, 0, "c40"};
    tbl[2] = '{0,  127,  127, 0, EXP_C127, 0, "c127"};
    tbl[3] = '{1,    1,  -20, 1,    -20, 1, "ident_neg"};
    tbl[4] = '{0, -128, -128, 0, EXP_CMIN, 0, "cmin"};
    tbl[5] = '{0,    1,    1, 1,    210, 0, "ones"};
    tbl[6] = '{0,   -1,  127, 0,  -2540, 0, "neg1"};

    reset = 1'b1; loadMatrix = 1'b0; loadVector = 1'b0; start = 1'b0; data_in = 8'sd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset done", int'(done), 0);
    check("reset data_out", int'(data_out), 0);

    for (int t = 0; t < 7; t++) begin
      fill(tbl[t]);
      load_matrix();
      load_vector();
      run_start(tbl[t].name, 1'b0);
    end

    // Stored A/x survive a reset; registered outputs clear.
    fill(tbl[5]);
    load_matrix();
    load_vector();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("rst_keep data_out", int'(data_out), 0);
    check("rst_keep done", int'(done), 0);
    run_start("rst_keep", 1'b0);

    // Back-to-back starts; loadMatrix during the first stream must be ignored.
    fill(tbl[0]);
    load_matrix();
    load_vector();
    run_start("b2b_1", 1'b1);
    run_start("b2b_2", 1'b0);
    @(negedge clk);
    check("hold data_out", int'(data_out), exp_y[N-1]);

    // Abort mid-compute, then recompute.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("abort done", int'(done), 0);
    run_start("after_abort", 1'b0);

    // Random ops with elements in [-40,40] against the reference model.
    for (int i = 0; i < N*N; i++) a_tb[i] = int'($urandom_range(80, 0)) - 40;
    for (int k = 0; k < N; k++) x_tb[k] = int'($urandom_range(80, 0)) - 40;
    load_matrix();
    load_vector();
    rst_op = int'($urandom_range(20, 5));
    for (int op = 0; op < 24; op++) begin
      if (op == rst_op) begin
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat ($urandom_range(300, 1)) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
      end
      case ($urandom_range(2, 0))
        0: begin
          for (int i = 0; i < N*N; i++) a_tb[i] = int'($urandom_range(80, 0)) - 40;
          load_matrix();
        end
        1: begin
          for (int k = 0; k < N; k++) x_tb[k] = int'($urandom_range(80, 0)) - 40;
          load_vector();
        end
        default: begin
          model_y();
          run_start($sformatf("rand%0d", op), 1'b0);
        end
      endcase
    end
    model_y();
    run_start("rand_final", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
